// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC and picks the next fetch address.
//
// Next-address sources: sequential pc+4, J-type jump target, branch target
// (base + offset*4) and JR register target. Priority is jr > jump > branch.
// The address is offered to instruction memory as pc/pc_valid and moves
// only when it is accepted (adv), when a buffered redirect is applied, or
// on reset. A redirect that arrives while fetch is blocked is buffered until
// the next accepted fetch. A misaligned JR target traps into HALT, and only
// reset leaves HALT.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   fetch_ready       instruction memory accepts pc this cycle
//   stall             pipeline hazard stall, blocks PC advance
//   jump/jump_target  one-cycle jump pulse and its target
//   branch/branch_*   one-cycle taken-branch pulse, base (PC+4) and offset
//   jr/jr_target      one-cycle register-jump pulse and its target
//   pc, pc_valid      fetch request
//   pc4               pc + 4 (combinational)
//   redirect_pending  a redirect is buffered, waiting for the handshake
//   misaligned        sticky trap flag
//
// state | meaning
// START | one cycle after reset, no fetch request yet
// RUN   | fetching, no redirect buffered
// HOLD  | fetching, redirect buffered in pending until next adv
// HALT  | misaligned JR trap, frozen until reset

module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        branch,
  input  logic [31:0] branch_base,
  input  logic [31:0] branch_offset,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic [31:0] pc4,
  output logic        redirect_pending,
  output logic        misaligned
);

  typedef enum logic [1:0] {START, RUN, HOLD, HALT} state_t;

  state_t      state, state_n;
  logic [31:0] pending, pending_n, pc_n;
  logic [31:0] target, branch_target;
  logic        adv, redirect, jr_bad;

  assign pc4 = pc + 32'd4;
  // Shifting the whole offset left by two drops the top two bits, which is
  // the same as using {offset[29:0], 2'b00}.
  assign branch_target = branch_base + (branch_offset << 2);
  assign adv      = pc_valid & fetch_ready & ~stall;
  assign redirect = jr | jump | branch;
  assign jr_bad   = jr & (jr_target[1:0] != 2'b00);

  always_comb begin
    target = branch_target;
    if (jr)
      target = jr_target;
    else if (jump)
      target = jump_target;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pending_n = pending;
    case (state)
      START: state_n = RUN;
      RUN: begin
        if (jr_bad) begin
          state_n = HALT;
        end else if (redirect) begin
          if (adv) begin
            pc_n = target;
          end else begin
            pending_n = target;
            state_n   = HOLD;
          end
        end else if (adv) begin
          pc_n = pc4;
        end
      end
      HOLD: begin
        if (jr_bad) begin
          state_n = HALT;
        end else if (adv) begin
          // A pulse in the same cycle as the handshake is newer than pending.
          pc_n    = redirect ? target : pending;
          state_n = RUN;
        end else if (redirect) begin
          pending_n = target;
        end
      end
      HALT: state_n = HALT;
      default: state_n = START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= START;
      pc               <= RESET_PC;
      pending          <= 32'h0000_0000;
      pc_valid         <= 1'b0;
      redirect_pending <= 1'b0;
      misaligned       <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      pending          <= pending_n;
      pc_valid         <= (state_n == RUN) || (state_n == HOLD);
      redirect_pending <= (state_n == HOLD);
      misaligned       <= (state_n == HALT);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, fetch_ready, stall;
  logic        jump, branch, jr;
  logic [31:0] jump_target, branch_base, branch_offset, jr_target;
  logic [31:0] pc, pc4;
  logic        pc_valid, redirect_pending, misaligned;

  int tests = 0;
  int fails = 0;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .fetch_ready(fetch_ready), .stall(stall),
    .jump(jump), .jump_target(jump_target),
    .branch(branch), .branch_base(branch_base), .branch_offset(branch_offset),
    .jr(jr), .jr_target(jr_target),
    .pc(pc), .pc_valid(pc_valid), .pc4(pc4),
    .redirect_pending(redirect_pending), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    jump = 1'b0; branch = 1'b0; jr = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; clear_pulses(); tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_ready = 1'b1; stall = 1'b0;
    jr = 1'b1; jr_target = 32'h0000_0042; jump = 1'b1; jump_target = 32'h100;
    branch = 1'b1; branch_base = 32'h10; branch_offset = 32'h4;
    tick();
    clear_pulses(); reset = 1'b0;
    tests++; if (pc !== RST_PC) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, RST_PC); end
    tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", pc_valid); end
    tests++; if (redirect_pending !== 1'b0) begin fails++; $display("FAIL reset_rp got %b exp 0", redirect_pending); end
    tests++; if (misaligned !== 1'b0) begin fails++; $display("FAIL reset_mis got %b exp 0", misaligned); end
  endtask

  task automatic test_sequential();
    do_reset();
    fetch_ready = 1'b1; stall = 1'b0;
    tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL start_valid got %b exp 0", pc_valid); end
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++;
      if (pc !== 32'(i * 4) || pc_valid !== 1'b1) begin
        fails++; $display("FAIL seq_pc%0d got %h/%b exp %h/1", i, pc, pc_valid, 32'(i * 4));
      end
    end
  endtask

  task automatic test_jump();
    jr = 1'b1; jr_target = 32'h0040_0010; tick(); jr = 1'b0;
    tests++; if (pc !== 32'h0040_0010) begin fails++; $display("FAIL jr_setup got %h exp 00400010", pc); end
    jump = 1'b1; jump_target = 32'h0040_0100; tick(); jump = 1'b0;
    tests++; if (pc !== 32'h0040_0100) begin fails++; $display("FAIL jump_pc got %h exp 00400100", pc); end
    tick();
    tests++; if (pc !== 32'h0040_0104) begin fails++; $display("FAIL jump_next got %h exp 00400104", pc); end
  endtask

  task automatic test_branch_stall();
    logic [31:0] p0;
    p0 = pc;
    stall = 1'b1;
    branch = 1'b1; branch_base = 32'h0000_1004; branch_offset = 32'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) begin
      tick(); branch = 1'b0;
      tests++;
      if (pc !== p0 || redirect_pending !== 1'b1) begin
        fails++; $display("FAIL stall_hold%0d got %h/%b exp %h/1", i, pc, redirect_pending, p0);
      end
    end
    stall = 1'b0; tick();
    tests++;
    if (pc !== 32'h0000_0FFC || redirect_pending !== 1'b0) begin
      fails++; $display("FAIL stall_apply got %h/%b exp 00000ffc/0", pc, redirect_pending);
    end
  endtask

  task automatic test_hold_overwrite();
    stall = 1'b1;
    branch = 1'b1; branch_base = 32'h0000_1000; branch_offset = 32'h0000_0400;
    tick();
    tests++; if (redirect_pending !== 1'b1) begin fails++; $display("FAIL hold_enter got %b exp 1", redirect_pending); end
    jr = 1'b1; jr_target = 32'h0000_3000;
    branch = 1'b1; branch_base = 32'h0000_5000; branch_offset = 32'h0000_0010;
    tick(); clear_pulses();
    stall = 1'b0; tick();
    tests++; if (pc !== 32'h0000_3000) begin fails++; $display("FAIL hold_overwrite got %h exp 00003000", pc); end
    tick();
    tests++; if (pc !== 32'h0000_3004) begin fails++; $display("FAIL hold_once got %h exp 00003004", pc); end
  endtask

  task automatic test_wrap();
    jr = 1'b1; jr_target = 32'hFFFF_FFFC; tick(); jr = 1'b0;
    tests++; if (pc4 !== 32'h0000_0000) begin fails++; $display("FAIL pc4_wrap got %h exp 00000000", pc4); end
    tick();
    tests++; if (pc !== 32'h0000_0000) begin fails++; $display("FAIL pc_wrap got %h exp 00000000", pc); end
    branch = 1'b1; branch_base = 32'hFFFF_FFF0; branch_offset = 32'h0000_0008;
    tick(); branch = 1'b0;
    tests++; if (pc !== 32'h0000_0010) begin fails++; $display("FAIL branch_wrap got %h exp 00000010", pc); end
  endtask

  task automatic test_misaligned();
    logic [31:0] p0;
    p0 = pc;
    jr = 1'b1; jr_target = 32'h0000_1002; tick(); jr = 1'b0;
    tests++;
    if (misaligned !== 1'b1 || pc_valid !== 1'b0 || pc !== p0 || redirect_pending !== 1'b0) begin
      fails++; $display("FAIL trap got mis=%b v=%b pc=%h rp=%b exp 1/0/%h/0", misaligned, pc_valid, pc, redirect_pending, p0);
    end
    jump = 1'b1; jump_target = 32'h0000_5000; tick();
    jump = 1'b0; jr = 1'b1; jr_target = 32'h0000_6000; tick(); jr = 1'b0;
    tests++;
    if (pc !== p0 || misaligned !== 1'b1 || pc_valid !== 1'b0) begin
      fails++; $display("FAIL halt_frozen got pc=%h mis=%b v=%b exp %h/1/0", pc, misaligned, pc_valid, p0);
    end
    do_reset();
    tests++;
    if (pc !== RST_PC || misaligned !== 1'b0 || pc_valid !== 1'b0) begin
      fails++; $display("FAIL halt_reset got pc=%h mis=%b v=%b exp %h/0/0", pc, misaligned, pc_valid, RST_PC);
    end
    tick();
    tests++; if (pc_valid !== 1'b1 || pc !== RST_PC) begin fails++; $display("FAIL halt_restart got v=%b pc=%h", pc_valid, pc); end
  endtask

  // Reference model: a pending redirect is just an optional address that
  // replaces pc+4 at the next accepted fetch; a newer pulse replaces it.
  task automatic test_random();
    logic [31:0] m_pc, m_ptgt, tgt;
    bit          m_start, m_halt, m_pend, m_valid, adv, any;
    do_reset();
    m_pc = RST_PC; m_start = 1; m_halt = 0; m_pend = 0; m_ptgt = 0; m_valid = 0;
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 79) == 0);
      fetch_ready   = ($urandom_range(0, 3) != 0);
      stall         = ($urandom_range(0, 3) == 0);
      jump          = ($urandom_range(0, 6) == 0);
      branch        = ($urandom_range(0, 6) == 0);
      jr            = ($urandom_range(0, 8) == 0);
      jump_target   = $urandom & 32'hFFFF_FFFC;
      branch_base   = $urandom & 32'hFFFF_FFFC;
      branch_offset = $urandom;
      jr_target     = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) jr_target[1:0] = 2'($urandom_range(1, 3));

      adv = m_valid && fetch_ready && !stall;
      any = jr || jump || branch;
      tgt = jr ? jr_target : jump ? jump_target : branch_base + branch_offset * 4;
      if (reset) begin
        m_pc = RST_PC; m_start = 1; m_halt = 0; m_pend = 0; m_valid = 0;
      end else if (m_halt) begin
      end else if (m_start) begin
        m_start = 0; m_valid = 1;
      end else if (jr && jr_target[1:0] != 2'b00) begin
        m_halt = 1; m_valid = 0; m_pend = 0;
      end else if (any && adv) begin
        m_pc = tgt; m_pend = 0;
      end else if (any) begin
        m_pend = 1; m_ptgt = tgt;
      end else if (adv) begin
        m_pc = m_pend ? m_ptgt : m_pc + 4; m_pend = 0;
      end

      tick();
      reset = 1'b0; clear_pulses();
      tests++;
      if (pc !== m_pc || pc_valid !== m_valid || redirect_pending !== m_pend ||
          misaligned !== m_halt || pc4 !== m_pc + 32'd4) begin
        fails++;
        $display("FAIL rand%0d got pc=%h v=%b rp=%b mis=%b pc4=%h exp pc=%h v=%b rp=%b mis=%b",
                 n, pc, pc_valid, redirect_pending, misaligned, pc4, m_pc, m_valid, m_pend, m_halt);
      end
    end
  endtask

  initial begin
    reset = 1'b1; fetch_ready = 1'b0; stall = 1'b0;
    jump = 1'b0; branch = 1'b0; jr = 1'b0;
    jump_target = '0; branch_base = '0; branch_offset = '0; jr_target = '0;
    #2;
    test_reset();
    test_sequential();
    test_jump();
    test_branch_stall();
    test_hold_overwrite();
    test_wrap();
    test_misaligned();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter sequencer. Owns the PC register and is the consumer of the jump target formed from instr[25:0] and PC+4.
- Chooses the next fetch address: sequential PC+4, J-type jump target, branch target or JR register target.
- Presents that address to instruction memory with a valid/ready handshake.
- Buffers a redirect that arrives while fetch is stalled, and traps misaligned register jumps.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_ready  input  1  instruction memory accepts pc this cycle.
- stall  input  1  pipeline hazard stall; blocks PC advance.
- jump  input  1  one-cycle pulse: take jump_target.
- jump_target  input  32  {PC4[31:28], instr[25:0], 2'b00} from the jump-address former.
- branch  input  1  one-cycle pulse: branch taken.
- branch_base  input  32  PC+4 of the branch instruction.
- branch_offset  input  32  sign-extended 16-bit immediate, not yet shifted.
- jr  input  1  one-cycle pulse: take jr_target.
- jr_target  input  32  register-sourced target.
- pc  output  32  current fetch address.
- pc_valid  output  1  pc is a valid fetch request.
- pc4  output  32  pc + 4, combinational from pc.
- redirect_pending  output  1  a redirect is buffered, awaiting handshake.
- misaligned  output  1  sticky trap flag.

Behaviour:
- Reset (clk edge with reset=1):
  - pc=RESET_PC, pc_valid=0, redirect_pending=0, misaligned=0.
  - Pending target register cleared; state=START.
  - Reset wins over every other input in that cycle, including mid-HOLD and HALT.
- States: START, RUN, HOLD, HALT.
- START:
  - Exactly one cycle; pc_valid=0; redirect pulses are ignored.
  - Next state RUN with pc_valid=1 and pc unchanged (RESET_PC).
- Handshake: adv = pc_valid & fetch_ready & ~stall. pc changes only on adv, a redirect apply, or reset.
- Target selection, priority jr > jump > branch. Only the highest-priority asserted pulse is used.
- Width rules (all arithmetic modulo 2^32, carries dropped):
  - branch target = branch_base + {branch_offset[29:0], 2'b00}.
  - pc4 wraps 32'hFFFF_FFFC -> 32'h0000_0000.
- RUN:
  - Redirect pulse with adv=1: pc <= selected target next edge; state stays RUN.
  - Redirect pulse with adv=0: pending <= selected target, redirect_pending=1, state HOLD; pc holds.
  - No redirect, adv=1: pc <= pc4.
  - No redirect, adv=0: pc holds.
- HOLD:
  - pc holds while adv=0.
  - A new redirect pulse overwrites pending; the last one wins.
  - On adv=1: pc <= pending, or the new target if a pulse arrives that same cycle (the new target wins). redirect_pending=0 and state RUN at the next edge.
  - The pending target is never skipped or applied twice.
- Latency: redirect is visible on pc 1 cycle after the pulse if adv=1, otherwise 1 cycle after the first adv cycle.
- Misaligned JR:
  - jr=1 with jr_target[1:0] != 0, in RUN or HOLD and regardless of adv, goes to HALT at the next edge.
  - HALT: misaligned=1, pc_valid=0, redirect_pending=0, pc frozen at its value from before the trap.
  - HALT exits only via reset.
- jump_target[1:0] and the branch target low bits are zero by construction and are not checked.
- All outputs are registered except pc4.

Test Plan:
- Reset, then fetch_ready=1, stall=0: pc_valid=0 in the first cycle. Then pc = 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- pc=0x0040_0010, jump pulse with jump_target=0x0040_0100, fetch_ready=1: next pc = 0x0040_0100, then 0x0040_0104.
- branch pulse with branch_base=0x0000_1004, branch_offset=0xFFFF_FFFE, while stall=1 for 3 cycles:
  - redirect_pending=1 and pc frozen during the stall.
  - On the first adv cycle pc = 0x0000_0FFC and redirect_pending drops to 0.
- In HOLD with pending 0x2000, jr pulse with jr_target=0x3000 plus a simultaneous branch: pending becomes 0x3000; after the handshake pc = 0x3000.
- pc=0xFFFF_FFFC, fetch_ready=1, no redirect: pc wraps to 0x0000_0000. Also branch_base=0xFFFF_FFF0 with offset 8 gives target 0x0000_0010.
- jr with jr_target=0x0000_1002:
  - Next cycle misaligned=1, pc_valid=0, pc unchanged; further pulses are ignored.
  - Asserting reset gives pc=RESET_PC, misaligned=0, then START -> RUN.
